regs_fetch: RTL

Operand-fetch stage directly upstream of the register memory in the picoMIPS datapath. It accepts a decoded instruction's two source addresses, sequences them through the memory's single synchronous read port, captures both operands and presents them to the ALU with a valid/ready handshake. It also owns the memory's write port for writeback, and forwards writes the memory read path would otherwise miss, because the memory returns pre-write data on a same-cycle read/write collision.

---
 rtl/regs_fetch.sv | 121 ++++++++++++
 1 files changed

// File: rtl/regs_fetch.sv
// Operand-fetch stage for the picoMIPS register memory: sequences both source reads through
// one synchronous read port, forwards same-cycle writebacks and hands operands to the ALU.
module regs_fetch #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [ADDR_WIDTH-1:0] src_a,
  input  logic [ADDR_WIDTH-1:0] src_b,
  input  logic [ADDR_WIDTH-1:0] dst,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [REG_WIDTH-1:0]  op_a,
  output logic [REG_WIDTH-1:0]  op_b,
  output logic [ADDR_WIDTH-1:0] op_dst,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [REG_WIDTH-1:0]  wb_data,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [REG_WIDTH-1:0]  mem_q,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [REG_WIDTH-1:0]  mem_d
);

  typedef enum logic [1:0] {IDLE, RD_B, CAP_B, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sa_lat;
  logic [ADDR_WIDTH-1:0] sb_lat;
  logic                  fwd_a;
  logic                  fwd_b;
  logic [REG_WIDTH-1:0]  fwd_a_data;
  logic [REG_WIDTH-1:0]  fwd_b_data;
  logic                  hit_a;
  logic                  hit_b;

  // The memory returns pre-write data on a collision, so a write landing in the capture
  // cycle wins, then any write caught since the read was launched, then the memory data.
  function automatic logic [REG_WIDTH-1:0] pick_operand(
    input logic                 hit_now,
    input logic [REG_WIDTH-1:0] now_data,
    input logic                 flag,
    input logic [REG_WIDTH-1:0] flag_data,
    input logic [REG_WIDTH-1:0] q
  );
    if (hit_now)   return now_data;
    else if (flag) return flag_data;
    else           return q;
  endfunction

  assign hit_a = wb_valid && (wb_addr == sa_lat);
  assign hit_b = wb_valid && (wb_addr == sb_lat);

  assign mem_rd_addr = (state == IDLE) ? src_a : sb_lat;
  assign mem_we      = wb_valid & ~reset;
  assign mem_wr_addr = wb_addr;
  assign mem_d       = wb_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      op_valid    <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_dst      <= '0;
      sa_lat      <= '0;
      sb_lat      <= '0;
      fwd_a       <= 1'b0;
      fwd_b       <= 1'b0;
      fwd_a_data  <= '0;
      fwd_b_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            sa_lat      <= src_a;
            sb_lat      <= src_b;
            op_dst      <= dst;
            fwd_a       <= wb_valid && (wb_addr == src_a);
            fwd_a_data  <= wb_data;
            fwd_b       <= 1'b0;
            fwd_b_data  <= '0;
            instr_ready <= 1'b0;
            state       <= RD_B;
          end
        end
        RD_B: begin
          op_a <= pick_operand(hit_a, wb_data, fwd_a, fwd_a_data, mem_q);
          // Operand B's read launches this cycle, so writes here are missed by the memory.
          if (hit_b) begin
            fwd_b      <= 1'b1;
            fwd_b_data <= wb_data;
          end
          state <= CAP_B;
        end
        CAP_B: begin
          op_b     <= pick_operand(hit_b, wb_data, fwd_b, fwd_b_data, mem_q);
          op_valid <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (op_ready) begin
            op_valid    <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            if (hit_a) op_a <= wb_data;
            if (hit_b) op_b <= wb_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
